// File: rtl/meta_plru_ctrl.sv
// Cache metadata read-modify-write pipeline: 4-way tree-PLRU update, fill victim choice and writeback flag.
// Build macro META_STATS_EN adds saturating fill/evict/write counters.
module meta_plru_ctrl #(
  parameter int SETS = 256,
  parameter int WAYS = 4,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [IDX_W-1:0] req_index,
  input  logic [1:0]       req_way,
  output logic [IDX_W-1:0] meta_rd_addr,
  input  logic [10:0]      meta_rd_data,
  output logic             meta_wr_en,
  output logic [IDX_W-1:0] meta_wr_addr,
  output logic [10:0]      meta_wr_data,
  output logic             resp_valid,
  output logic [1:0]       resp_way,
  output logic             resp_evict
`ifdef META_STATS_EN
  ,
  output logic [31:0]      stat_fills,
  output logic [31:0]      stat_evicts,
  output logic [31:0]      stat_writes
`endif
);

  localparam logic [1:0] OP_TOUCH = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_INVAL = 2'b11;

  if (WAYS != 4) begin : g_ways_check
    $error("meta_plru_ctrl supports WAYS == 4 only");
  end

  logic             ready_q, ready_d;
  logic             s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [1:0]       s1_op_q, s1_op_d, s2_op_q, s2_op_d;
  logic [1:0]       s1_way_q, s1_way_d, s2_way_q, s2_way_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d;
  logic             fwd_vld_q, fwd_vld_d;
  logic [IDX_W-1:0] fwd_idx_q, fwd_idx_d;
  logic [10:0]      fwd_data_q, fwd_data_d;
  logic             resp_valid_q, resp_valid_d;
  logic [1:0]       resp_way_q, resp_way_d;
  logic             resp_evict_q, resp_evict_d;

  logic [10:0] old_entry, new_entry;
  logic [3:0]  old_v, old_d, new_v, new_d;
  logic [2:0]  old_p, new_p;
  logic [1:0]  victim, tgt_way;
  logic        evict;

  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] r;
    r = p;
    if (!w[1]) begin
      r[0] = 1'b1;
      r[1] = ~w[0];
    end else begin
      r[0] = 1'b0;
      r[2] = ~w[0];
    end
    return r;
  endfunction

  // The array returns data two cycles late, so the previous op's result must override a same-index read.
  always_comb begin
    old_entry = meta_rd_data;
    if (fwd_vld_q && (fwd_idx_q == s2_idx_q)) old_entry = fwd_data_q;
    old_v = old_entry[10:7];
    old_d = old_entry[6:3];
    old_p = old_entry[2:0];
  end

  always_comb begin
    victim = 2'd0;
    if (!old_v[0])      victim = 2'd0;
    else if (!old_v[1]) victim = 2'd1;
    else if (!old_v[2]) victim = 2'd2;
    else if (!old_v[3]) victim = 2'd3;
    else if (old_p[0])  victim = {1'b1, old_p[2]};
    else                victim = {1'b0, old_p[1]};
  end

  always_comb begin
    tgt_way = (s2_op_q == OP_FILL) ? victim : s2_way_q;
    new_v   = old_v;
    new_d   = old_d;
    new_p   = old_p;
    evict   = 1'b0;
    case (s2_op_q)
      OP_TOUCH: new_p = plru_touch(old_p, tgt_way);
      OP_WRITE: begin
        new_p          = plru_touch(old_p, tgt_way);
        new_d[tgt_way] = 1'b1;
      end
      OP_FILL: begin
        evict          = old_v[tgt_way] && old_d[tgt_way];
        new_v[tgt_way] = 1'b1;
        new_d[tgt_way] = 1'b0;
        new_p          = plru_touch(old_p, tgt_way);
      end
      OP_INVAL: begin
        new_v[tgt_way] = 1'b0;
        new_d[tgt_way] = 1'b0;
      end
      default: ;
    endcase
    new_entry = {new_v, new_d, new_p};
  end

  always_comb begin
    ready_d      = 1'b1;
    s1_vld_d     = req_valid && ready_q;
    s1_op_d      = req_op;
    s1_idx_d     = req_index;
    s1_way_d     = req_way;
    s2_vld_d     = s1_vld_q;
    s2_op_d      = s1_op_q;
    s2_idx_d     = s1_idx_q;
    s2_way_d     = s1_way_q;
    fwd_vld_d    = s2_vld_q;
    fwd_idx_d    = s2_idx_q;
    fwd_data_d   = new_entry;
    resp_valid_d = s2_vld_q;
    resp_way_d   = s2_vld_q ? tgt_way : 2'd0;
    resp_evict_d = s2_vld_q && evict;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_op_q      <= 2'd0;
      s1_idx_q     <= '0;
      s1_way_q     <= 2'd0;
      s2_vld_q     <= 1'b0;
      s2_op_q      <= 2'd0;
      s2_idx_q     <= '0;
      s2_way_q     <= 2'd0;
      fwd_vld_q    <= 1'b0;
      fwd_idx_q    <= '0;
      fwd_data_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_way_q   <= 2'd0;
      resp_evict_q <= 1'b0;
    end else begin
      ready_q      <= ready_d;
      s1_vld_q     <= s1_vld_d;
      s1_op_q      <= s1_op_d;
      s1_idx_q     <= s1_idx_d;
      s1_way_q     <= s1_way_d;
      s2_vld_q     <= s2_vld_d;
      s2_op_q      <= s2_op_d;
      s2_idx_q     <= s2_idx_d;
      s2_way_q     <= s2_way_d;
      fwd_vld_q    <= fwd_vld_d;
      fwd_idx_q    <= fwd_idx_d;
      fwd_data_q   <= fwd_data_d;
      resp_valid_q <= resp_valid_d;
      resp_way_q   <= resp_way_d;
      resp_evict_q <= resp_evict_d;
    end
  end

  assign req_ready    = ready_q;
  assign meta_rd_addr = ready_q ? req_index : '0;
  assign meta_wr_en   = s2_vld_q;
  assign meta_wr_addr = s2_vld_q ? s2_idx_q : '0;
  assign meta_wr_data = s2_vld_q ? new_entry : '0;
  assign resp_valid   = resp_valid_q;
  assign resp_way     = resp_way_q;
  assign resp_evict   = resp_evict_q;

`ifdef META_STATS_EN
  logic [31:0] stat_fills_q, stat_fills_d;
  logic [31:0] stat_evicts_q, stat_evicts_d;
  logic [31:0] stat_writes_q, stat_writes_d;

  always_comb begin
    stat_fills_d  = stat_fills_q;
    stat_evicts_d = stat_evicts_q;
    stat_writes_d = stat_writes_q;
    if (s2_vld_q && (s2_op_q == OP_FILL) && (stat_fills_q != '1))
      stat_fills_d = stat_fills_q + 32'd1;
    if (s2_vld_q && (s2_op_q == OP_FILL) && evict && (stat_evicts_q != '1))
      stat_evicts_d = stat_evicts_q + 32'd1;
    if (s2_vld_q && (s2_op_q == OP_WRITE) && (stat_writes_q != '1))
      stat_writes_d = stat_writes_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fills_q  <= '0;
      stat_evicts_q <= '0;
      stat_writes_q <= '0;
    end else begin
      stat_fills_q  <= stat_fills_d;
      stat_evicts_q <= stat_evicts_d;
      stat_writes_q <= stat_writes_d;
    end
  end

  assign stat_fills  = stat_fills_q;
  assign stat_evicts = stat_evicts_q;
  assign stat_writes = stat_writes_q;
`endif

endmodule

// File: tb/tb_meta_plru_ctrl.sv
// Bench for meta_plru_ctrl: directed and random ops against a per-set reference model plus a 2-cycle array model.
module tb_meta_plru_ctrl;
  localparam logic [1:0] OP_TOUCH = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;
  localparam logic [1:0] OP_INVAL = 2'd3;

  logic        clk, rst_n, req_valid, req_ready;
  logic [1:0]  req_op, req_way, resp_way;
  logic [7:0]  req_index, meta_rd_addr, meta_wr_addr;
  logic [10:0] meta_rd_data, meta_wr_data;
  logic        meta_wr_en, resp_valid, resp_evict;
`ifdef META_STATS_EN
  logic [31:0] stat_fills, stat_evicts, stat_writes;
`endif

  meta_plru_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .req_way(req_way),
    .meta_rd_addr(meta_rd_addr), .meta_rd_data(meta_rd_data),
    .meta_wr_en(meta_wr_en), .meta_wr_addr(meta_wr_addr), .meta_wr_data(meta_wr_data),
    .resp_valid(resp_valid), .resp_way(resp_way), .resp_evict(resp_evict)
`ifdef META_STATS_EN
    , .stat_fills(stat_fills), .stat_evicts(stat_evicts), .stat_writes(stat_writes)
`endif
  );

  always #5 clk = ~clk;

  // Array: address registered on one edge, data read and registered on the next.
  logic [10:0] mem [256];
  logic [7:0]  rd_addr_q;
  logic [10:0] rd_data_q;
  always @(posedge clk) begin
    if (meta_wr_en) mem[meta_wr_addr] <= meta_wr_data;
    rd_addr_q <= meta_rd_addr;
    rd_data_q <= mem[rd_addr_q];
  end
  assign meta_rd_data = rd_data_q;

  typedef struct packed {
    logic        vld;
    logic [7:0]  idx;
    logic [10:0] wdata;
    logic [1:0]  way;
    logic        evict;
  } item_t;

  item_t      hist [4];
  logic [3:0] m_val [256];
  logic [3:0] m_dty [256];
  logic [2:0] m_plru [256];
  int         m_fills, m_evicts, m_writes;
  logic       exp_ready;
  logic [2:0] log_q [$];
  int         n_checks, n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic [2:0] touch(input logic [2:0] p, input int w);
    logic [2:0] r;
    r = p;
    if (w < 2) begin
      r[0] = 1'b1;
      r[1] = (w == 0);
    end else begin
      r[0] = 1'b0;
      r[2] = (w == 2);
    end
    return r;
  endfunction

  // Sequential semantics: each accepted op sees every earlier op's result on the same set.
  task automatic model_apply(input logic [1:0] op, input logic [7:0] idx, input logic [1:0] way,
                             output item_t it);
    logic [3:0] v, d;
    logic [2:0] p;
    int w;
    v = m_val[idx]; d = m_dty[idx]; p = m_plru[idx];
    w = int'(way);
    it = '0;
    it.vld = 1'b1;
    it.idx = idx;
    case (op)
      OP_TOUCH: p = touch(p, w);
      OP_WRITE: begin p = touch(p, w); d[w] = 1'b1; m_writes++; end
      OP_FILL: begin
        w = -1;
        for (int i = 0; i < 4; i++) if (!v[i] && w < 0) w = i;
        if (w < 0) begin
          if (p[0]) w = p[2] ? 3 : 2;
          else      w = p[1] ? 1 : 0;
        end
        it.evict = v[w] && d[w];
        v[w] = 1'b1; d[w] = 1'b0; p = touch(p, w);
        m_fills++;
        if (it.evict) m_evicts++;
      end
      default: begin v[w] = 1'b0; d[w] = 1'b0; end
    endcase
    it.way = 2'(w);
    it.wdata = {v, d, p};
    m_val[idx] = v; m_dty[idx] = d; m_plru[idx] = p;
  endtask

  task automatic cyc(input logic v, input logic [1:0] op, input logic [7:0] idx, input logic [1:0] way);
    item_t it;
    it = '0;
    req_valid = v; req_op = op; req_index = idx; req_way = way;
    if (v && exp_ready) model_apply(op, idx, way, it);
    hist[0] = it;
    #1;
    chk("req_ready", req_ready, exp_ready);
    if (v && exp_ready) chk("rd_addr", meta_rd_addr, idx);
    chk("wr_en", meta_wr_en, hist[2].vld);
    if (hist[2].vld) begin
      chk("wr_addr", meta_wr_addr, hist[2].idx);
      chk("wr_data", meta_wr_data, hist[2].wdata);
    end
    chk("resp_valid", resp_valid, hist[3].vld);
    chk("resp_way", resp_way, hist[3].way);
    chk("resp_evict", resp_evict, hist[3].evict);
    if (resp_valid) log_q.push_back({resp_way, resp_evict});
    @(posedge clk); #1;
    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = '0;
  endtask

  task automatic drain(input int n);
    repeat (n) cyc(1'b0, OP_TOUCH, 8'd0, 2'd0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    m_fills = 0; m_evicts = 0; m_writes = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0; m_val[i] = '0; m_dty[i] = '0; m_plru[i] = '0;
    end
    for (int i = 0; i < 4; i++) hist[i] = '0;
    rd_addr_q = '0; rd_data_q = '0;
    clk = 0; rst_n = 0; req_valid = 0; req_op = 0; req_index = 0; req_way = 0;
    exp_ready = 0;

    #12;
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_wr_en", meta_wr_en, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_way", resp_way, 2'd0);
    chk("rst_resp_evict", resp_evict, 1'b0);
    @(negedge clk); rst_n = 1; #1;
    chk("ready_before_edge", req_ready, 1'b0);
    @(posedge clk); #1;
    exp_ready = 1;

    // Set 5: four fills, touch way0, fill picks PLRU way2
    for (int i = 0; i < 4; i++) cyc(1'b1, OP_FILL, 8'd5, 2'd0);
    cyc(1'b1, OP_TOUCH, 8'd5, 2'd0);
    cyc(1'b1, OP_FILL, 8'd5, 2'd3);
    drain(4);
    chk("mem5_final", mem[5], 11'b1111_0000_110);

    // Set 9: write then five back-to-back fills
    cyc(1'b1, OP_WRITE, 8'd9, 2'd1);
    for (int i = 0; i < 5; i++) cyc(1'b1, OP_FILL, 8'd9, 2'd0);
    drain(4);

    // Set 3: fill full, invalidate way2, refill lands in way2
    for (int i = 0; i < 4; i++) cyc(1'b1, OP_FILL, 8'd3, 2'd0);
    cyc(1'b1, OP_INVAL, 8'd3, 2'd2);
    cyc(1'b1, OP_FILL, 8'd3, 2'd0);
    drain(4);

    chk("log_size", log_q.size(), 18);
    if (log_q.size() >= 18) begin
      for (int i = 0; i < 4; i++) chk("fill5_way", log_q[i], {i[1:0], 1'b0});
      chk("fill5_plru", log_q[5], {2'd2, 1'b0});
      chk("fill9_fifth", log_q[11], {2'd0, 1'b0});
      chk("inval3_resp", log_q[16], {2'd2, 1'b0});
      chk("fill3_after_inval", log_q[17], {2'd2, 1'b0});
    end

    repeat (400) begin
      logic       rv;
      logic [1:0] rop, rway;
      logic [7:0] ridx;
      rv   = ($urandom_range(0, 3) != 0);
      rop  = 2'($urandom_range(0, 3));
      ridx = 8'(16 + $urandom_range(0, 3));
      rway = 2'($urandom_range(0, 3));
      cyc(rv, rop, ridx, rway);
    end
    drain(4);

    // Reset with two requests in flight: neither may write or respond
    req_valid = 1; req_op = OP_FILL; req_index = 8'd30; req_way = 0;
    @(posedge clk); #1;
    req_index = 8'd31;
    @(posedge clk);
    rst_n = 0; req_valid = 0;
    exp_ready = 0;
    m_fills = 0; m_evicts = 0; m_writes = 0;
    for (int i = 0; i < 4; i++) hist[i] = '0;
    #1;
    chk("rstmid_wr_en", meta_wr_en, 1'b0);
    chk("rstmid_resp", resp_valid, 1'b0);
    chk("rstmid_ready", req_ready, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rstmid_wr_en_hold", meta_wr_en, 1'b0);
      chk("rstmid_resp_hold", resp_valid, 1'b0);
    end
    @(negedge clk); rst_n = 1; #1;
    chk("rstmid_ready_low", req_ready, 1'b0);
    @(posedge clk); #1;
    exp_ready = 1;
    drain(4);
    chk("mem30_untouched", mem[30], 11'd0);
    chk("mem31_untouched", mem[31], 11'd0);

    // Set 7: fill, dirty every way, three fills evict dirty lines
    log_q.delete();
    for (int i = 0; i < 4; i++) cyc(1'b1, OP_FILL, 8'd7, 2'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, OP_WRITE, 8'd7, 2'(i));
    for (int i = 0; i < 3; i++) cyc(1'b1, OP_FILL, 8'd7, 2'd0);
    drain(4);
    chk("log7_size", log_q.size(), 11);
    if (log_q.size() >= 11) begin
      chk("evict7_a", log_q[8], {2'd0, 1'b1});
      chk("evict7_b", log_q[9], {2'd2, 1'b1});
      chk("evict7_c", log_q[10], {2'd1, 1'b1});
    end

`ifdef META_STATS_EN
    chk("stat_fills", stat_fills, 32'(m_fills));
    chk("stat_evicts", stat_evicts, 32'(m_evicts));
    chk("stat_writes", stat_writes, 32'(m_writes));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
